// File: rtl/bit_serial_alu_sequencer_pkg.sv
// rtl/bit_serial_alu_sequencer_pkg.sv - shared states and function-code encodings
// Shared by the sequencer, the 1-bit ALU slice and their benches.
package bit_serial_alu_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } seq_state_t;

    // Function-code bit positions: F3 inverts A, F2 enables B, F1:F0 select.
    localparam int F0 = 0;
    localparam int F1 = 1;
    localparam int F2 = 2;
    localparam int F3 = 3;

    localparam logic [1:0] SEL_AND = 2'b00;
    localparam logic [1:0] SEL_OR  = 2'b01;
    localparam logic [1:0] SEL_XOR = 2'b10;
    localparam logic [1:0] SEL_ADD = 2'b11;

endpackage

// File: rtl/bit_serial_alu_sequencer_shift_reg.sv
// rtl/bit_serial_alu_sequencer_shift_reg.sv - WIDTH-bit load / shift-right / serial-in register
// Parallel load wins over shift; serial input enters at the MSB.
module serial_shift_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_data_i,
    input  logic             shift_i,
    input  logic             serial_i,
    output logic [WIDTH-1:0] data_o
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    always_comb begin
        data_d = data_q;
        if (load_i) begin
            data_d = load_data_i;
        end else if (shift_i) begin
            data_d = {serial_i, data_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/bit_serial_alu_sequencer.sv
// rtl/bit_serial_alu_sequencer.sv - bit-serial operand/result sequencer around a 1-bit ALU slice
// Operands stream LSB first; the slice carry is registered and fed back next cycle.
module bit_serial_alu_sequencer
    import bit_serial_alu_sequencer_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [3:0]       op_i,
    input  logic             cin_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             alu_a_o,
    output logic             alu_b_o,
    output logic [3:0]       alu_f_o,
    output logic             alu_carry_o,
    input  logic             alu_result_i,
    input  logic             alu_carry_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic             carry_o,
    output logic             zero_o
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    seq_state_t       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic [3:0]       f_q, f_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             carry_out_q, carry_out_d;
    logic             zero_q, zero_d;

    logic             accept;
    logic             shifting;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] res_next;
    logic             unused_bits;

    assign accept   = (state_q == ST_IDLE) && start_i;
    assign shifting = (state_q == ST_SHIFT);
    // Value res_q takes at this edge; captured directly so result_o is valid with done_o.
    assign res_next = {alu_result_i, res_q[WIDTH-1:1]};

    serial_shift_reg #(.WIDTH(WIDTH)) u_a_sr (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .load_i      (accept),
        .load_data_i (a_i),
        .shift_i     (shifting),
        .serial_i    (1'b0),
        .data_o      (a_q)
    );

    serial_shift_reg #(.WIDTH(WIDTH)) u_b_sr (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .load_i      (accept),
        .load_data_i (b_i),
        .shift_i     (shifting),
        .serial_i    (1'b0),
        .data_o      (b_q)
    );

    serial_shift_reg #(.WIDTH(WIDTH)) u_res_sr (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .load_i      (accept),
        .load_data_i ({WIDTH{1'b0}}),
        .shift_i     (shifting),
        .serial_i    (alu_result_i),
        .data_o      (res_q)
    );

    assign unused_bits = ^{a_q[WIDTH-1:1], b_q[WIDTH-1:1]};

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        carry_d     = carry_q;
        f_d         = f_q;
        result_d    = result_q;
        carry_out_d = carry_out_q;
        zero_d      = zero_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_SHIFT;
                    cnt_d   = '0;
                    carry_d = cin_i;
                    f_d     = op_i;
                end
            end
            ST_SHIFT: begin
                carry_d = alu_carry_i;
                if (cnt_q == LAST_BIT) begin
                    state_d     = ST_DONE;
                    result_d    = res_next;
                    carry_out_d = alu_carry_i;
                    zero_d      = (res_next == '0);
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            f_q         <= 4'd0;
            result_q    <= '0;
            carry_out_q <= 1'b0;
            zero_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            carry_q     <= carry_d;
            f_q         <= f_d;
            result_q    <= result_d;
            carry_out_q <= carry_out_d;
            zero_q      <= zero_d;
        end
    end

    assign alu_a_o     = shifting & a_q[0];
    assign alu_b_o     = shifting & b_q[0];
    assign alu_carry_o = shifting & carry_q;
    assign alu_f_o     = f_q;
    assign busy_o      = (state_q == ST_SHIFT) || (state_q == ST_DONE);
    assign done_o      = (state_q == ST_DONE);
    assign result_o    = result_q;
    assign carry_o     = carry_out_q;
    assign zero_o      = zero_q;

endmodule

// File: tb/tb_bit_serial_alu_sequencer.sv
// tb/tb_bit_serial_alu_sequencer.sv - directed vector bench with a behavioural 1-bit ALU slice
// Slice carry is always the full-adder carry of the conditioned A/B bits.
module tb_bit_serial_alu_sequencer;
    import bit_serial_alu_sequencer_pkg::*;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [3:0]   op;
    logic         cin;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         alu_a, alu_b, alu_carry;
    logic [3:0]   alu_f;
    logic         alu_result, alu_cout;
    logic         busy, done;
    logic [W-1:0] result;
    logic         carry, zero;

    always #5 clk = ~clk;

    bit_serial_alu_sequencer #(.WIDTH(W)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .start_i      (start),
        .op_i         (op),
        .cin_i        (cin),
        .a_i          (a),
        .b_i          (b),
        .alu_a_o      (alu_a),
        .alu_b_o      (alu_b),
        .alu_f_o      (alu_f),
        .alu_carry_o  (alu_carry),
        .alu_result_i (alu_result),
        .alu_carry_i  (alu_cout),
        .busy_o       (busy),
        .done_o       (done),
        .result_o     (result),
        .carry_o      (carry),
        .zero_o       (zero)
    );

    logic sa, sb;
    always_comb begin
        sa = alu_f[F3] ? ~alu_a : alu_a;
        sb = alu_f[F2] & alu_b;
        case (alu_f[F1:F0])
            SEL_AND: alu_result = sa & sb;
            SEL_OR:  alu_result = sa | sb;
            SEL_XOR: alu_result = sa ^ sb;
            default: alu_result = sa ^ sb ^ alu_carry;
        endcase
        alu_cout = (sa & sb) | (sa & alu_carry) | (sb & alu_carry);
    end

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [3:0]   op;
        logic         cin;
        logic [W-1:0] exp_res;
        logic         exp_carry;
        logic         exp_zero;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic run_op(input vec_t v, output int done_cyc, output int busy_cnt,
                          output logic [W-1:0] r, output logic c, output logic z);
        done_cyc = -1;
        busy_cnt = 0;
        r = '0; c = 1'b0; z = 1'b0;
        @(negedge clk);
        a = v.a; b = v.b; op = v.op; cin = v.cin; start = 1'b1;
        @(posedge clk);
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (busy) busy_cnt++;
            if (done) begin
                done_cyc = cyc;
                r = result; c = carry; z = zero;
                break;
            end
        end
        @(negedge clk);
        check("done_single_pulse", {31'd0, done}, 32'd0);
    endtask

    vec_t vecs[11];

    initial begin
        int dc, bc, dones, busy_total, first_done, second_done, low_cyc;
        logic [W-1:0] r, first_res, second_res;
        logic c, z, first_c;

        vecs[0]  = '{8'h3C, 8'hC4, 4'b0111, 1'b0, 8'h00, 1'b1, 1'b1};
        vecs[1]  = '{8'h05, 8'h12, 4'b1111, 1'b1, 8'h0D, 1'b1, 1'b0};
        vecs[2]  = '{8'hF0, 8'h3C, 4'b0100, 1'b0, 8'h30, 1'b1, 1'b0};
        vecs[3]  = '{8'hA5, 8'hFF, 4'b0010, 1'b0, 8'hA5, 1'b0, 1'b0};
        vecs[4]  = '{8'h12, 8'h21, 4'b0101, 1'b0, 8'h33, 1'b0, 1'b0};
        vecs[5]  = '{8'hFF, 8'h01, 4'b0111, 1'b0, 8'h00, 1'b1, 1'b1};
        vecs[6]  = '{8'h7F, 8'h00, 4'b0111, 1'b1, 8'h80, 1'b0, 1'b0};
        vecs[7]  = '{8'h0F, 8'hAA, 4'b1010, 1'b0, 8'hF0, 1'b0, 1'b0};
        vecs[8]  = '{8'h0F, 8'hF0, 4'b0100, 1'b1, 8'h00, 1'b1, 1'b1};
        vecs[9]  = '{8'h33, 8'h33, 4'b1111, 1'b1, 8'h00, 1'b1, 1'b1};
        vecs[10] = '{8'h12, 8'h05, 4'b1111, 1'b1, 8'hF3, 1'b0, 1'b0};

        rst = 1'b1; start = 1'b0; op = 4'd0; cin = 1'b0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_busy",   {31'd0, busy},  32'd0);
        check("reset_done",   {31'd0, done},  32'd0);
        check("reset_result", {24'd0, result}, 32'd0);
        check("reset_carry",  {31'd0, carry}, 32'd0);
        check("reset_zero",   {31'd0, zero},  32'd0);
        check("reset_alu_f",  {28'd0, alu_f}, 32'd0);

        for (int i = 0; i < 11; i++) begin
            run_op(vecs[i], dc, bc, r, c, z);
            check($sformatf("v%0d_done_cycle", i), dc, 32'd9);
            check($sformatf("v%0d_busy_cycles", i), bc, 32'd9);
            check($sformatf("v%0d_result", i), {24'd0, r}, {24'd0, vecs[i].exp_res});
            check($sformatf("v%0d_carry", i), {31'd0, c}, {31'd0, vecs[i].exp_carry});
            check($sformatf("v%0d_zero", i), {31'd0, z}, {31'd0, vecs[i].exp_zero});
            check($sformatf("v%0d_result_held", i), {24'd0, result}, {24'd0, vecs[i].exp_res});
            check($sformatf("v%0d_idle_alu_a", i), {31'd0, alu_a}, 32'd0);
            check($sformatf("v%0d_idle_alu_f", i), {28'd0, alu_f}, {28'd0, vecs[i].op});
        end

        // start held high across two operations, a_i changed mid-flight
        first_done = -1; second_done = -1; low_cyc = -1; busy_total = 0;
        first_res = '0; second_res = '0; first_c = 1'b0;
        @(negedge clk);
        a = 8'h3C; b = 8'hC4; op = 4'b0111; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        for (int cyc = 1; cyc <= 30; cyc++) begin
            @(negedge clk);
            if (cyc == 3) a = 8'h01;
            if (busy) busy_total++;
            else if (low_cyc < 0) low_cyc = cyc;
            if (done && first_done < 0) begin
                first_done = cyc; first_res = result; first_c = carry;
            end else if (done && second_done < 0) begin
                second_done = cyc; second_res = result; start = 1'b0;
            end
            if (second_done > 0 && cyc > second_done) break;
        end
        check("hs_first_done",   first_done, 32'd9);
        check("hs_first_result", {24'd0, first_res}, 32'h00);
        check("hs_first_carry",  {31'd0, first_c}, 32'd1);
        check("hs_idle_gap",     low_cyc, 32'd10);
        check("hs_second_done",  second_done, 32'd19);
        check("hs_second_result", {24'd0, second_res}, 32'hC5);
        check("hs_busy_total",   busy_total, 32'd18);

        // reset during SHIFT cycle 4 after a zero-result op
        run_op(vecs[0], dc, bc, r, c, z);
        check("pre_reset_zero", {31'd0, zero}, 32'd1);
        @(negedge clk);
        a = 8'h55; b = 8'hAA; op = 4'b0111; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        for (int cyc = 1; cyc <= 4; cyc++) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_busy",   {31'd0, busy},   32'd0);
        check("rst_mid_done",   {31'd0, done},   32'd0);
        check("rst_mid_result", {24'd0, result}, 32'd0);
        check("rst_mid_zero",   {31'd0, zero},   32'd0);
        check("rst_mid_carry",  {31'd0, carry},  32'd0);
        dones = 0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            @(negedge clk);
            if (done || busy) dones++;
        end
        check("rst_mid_no_activity", dones, 32'd0);
        run_op('{8'h01, 8'h01, 4'b0111, 1'b0, 8'h02, 1'b0, 1'b0}, dc, bc, r, c, z);
        check("post_rst_done_cycle", dc, 32'd9);
        check("post_rst_result", {24'd0, r}, 32'h02);
        check("post_rst_carry",  {31'd0, c}, 32'd0);
        check("post_rst_zero",   {31'd0, z}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bit_serial_alu_sequencer.md
Name: bit_serial_alu_sequencer

Overview:
Bit-serial controller that sits on both sides of the 1-bit ALU slice. It loads WIDTH-bit operands, presents one bit pair per cycle (LSB first) with the function code to the slice, and carries the slice's carry-out back in as the next cycle's carry-in. It collects the result bits into a WIDTH-bit word with final carry and zero flags, under a start/busy/done handshake.

Parameters:
WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
clk_i  input  1  clock; all state updates on the rising edge.
rst_i  input  1  synchronous, active-high reset.
start_i  input  1  request a new operation; accepted only in IDLE.
op_i  input  4  function code; latched on accept; bit F3 inverts A, bit F2 enables B, bits F1:F0 select the result (00 AND, 01 OR, 10 XOR, 11 ADD).
cin_i  input  1  initial carry-in; latched on accept.
a_i  input  WIDTH  operand A; latched on accept.
b_i  input  WIDTH  operand B; latched on accept.
alu_a_o  output  1  current A bit to the slice.
alu_b_o  output  1  current B bit to the slice.
alu_f_o  output  4  latched function code to the slice.
alu_carry_o  output  1  carry-in to the slice.
alu_result_i  input  1  result bit from the slice (combinational, same cycle).
alu_carry_i  input  1  carry-out from the slice (combinational, same cycle).
busy_o  output  1  high while in SHIFT or DONE.
done_o  output  1  single-cycle pulse when the result is valid.
result_o  output  WIDTH  assembled result; held until the next accept.
carry_o  output  1  final carry, i.e. the last sampled alu_carry_i.
zero_o  output  1  high when result_o == 0; same timing as result_o.

Behaviour:
- Reset, or rst_i high in any state: state returns to IDLE and every output register clears to 0. This includes result_o, carry_o, zero_o (0, not 1), done_o, busy_o, and alu_f_o. Any operation in progress is discarded.
- FSM has three states: IDLE, SHIFT, DONE.
- IDLE, start_i=1:
  - latch a_i, b_i, op_i into a_q, b_q, f_q.
  - carry_q <= cin_i; bit counter <= 0.
  - go to SHIFT.
- IDLE, start_i=0: stay; all outputs hold.
- SHIFT, every cycle:
  - alu_a_o = a_q[0], alu_b_o = b_q[0], alu_carry_o = carry_q, alu_f_o = f_q. All are driven from registers.
  - At the edge: a_q and b_q shift right by 1.
  - res_q shifts right by 1, with alu_result_i inserted at the MSB.
  - carry_q <= alu_carry_i; counter increments.
- SHIFT exit: after the cycle with counter == WIDTH-1, go to DONE. SHIFT therefore lasts exactly WIDTH cycles.
- DONE (1 cycle):
  - done_o = 1; result_o <= res_q; carry_o <= carry_q; zero_o <= (res_q == 0).
  - Next state is IDLE.
- Latency: start_i accepted at edge 0; done_o is high during cycle WIDTH+1; a new start can be accepted at the edge ending that cycle+1 (IDLE).
- start_i during SHIFT or DONE is ignored; it is neither queued nor allowed to disturb the operation in flight.
- Operand inputs are sampled only on accept; changes during busy are ignored.
- In IDLE and DONE, alu_a_o, alu_b_o, and alu_carry_o drive 0; alu_f_o holds f_q.
- For non-ADD codes the carry is still chained; carry_o reports whatever the slice returns.
- Arithmetic is modulo 2^WIDTH. Subtract B−A uses F3=1, F2=1, ADD, cin_i=1; for this operation carry_o=1 means no borrow.
- Bit counter width is $clog2(WIDTH); there is no wrap beyond WIDTH-1.

Decomposition:
- Shared package holds:
  - state enum (IDLE, SHIFT, DONE);
  - function-bit index constants F0..F3;
  - result-select encodings AND/OR/XOR/ADD.
- The package is shared with the ALU slice and its bench.
- One natural sub-module: serial_shift_reg (WIDTH-bit, load/shift-right/serial-in). It is instantiated three times: A, B, and result.
- The FSM and carry register stay in the top level.

Test Plan:
- ADD, WIDTH=8: a=8'h3C, b=8'hC4, op=4'b0111, cin=0 -> after 9 cycles, done_o pulses with result_o=8'h00, carry_o=1, zero_o=1.
- SUB B−A: a=8'h05, b=8'h12, op=4'b1111, cin=1 -> result_o=8'h0D, carry_o=1, zero_o=0.
- AND: a=8'hF0, b=8'h3C, op=4'b0100 -> result_o=8'h30.
- XOR with B disabled: a=8'hA5, b=8'hFF, op=4'b0010 -> result_o=8'hA5, because B is forced to 0.
- Handshake: assert start_i continuously across two operations -> second operation starts only from IDLE. Changes to a_i mid-operation do not alter the result. busy_o is high for exactly 9 cycles per operation.
- Reset mid-operation: rst_i at SHIFT cycle 4 -> next cycle is IDLE with busy_o=0, result_o=0, zero_o=0, and no done_o pulse. A following ADD 8'h01+8'h01 gives 8'h02.
